// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller.
// Contents: instruction_t (IR field layout), opcode_t, instruction class,
// FSM state, datapath select encodings, trap causes and the funct3 -> ALU
// operation mapping shared by OP and OP-IMM.
package multicycle_ctrl_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_IMM    = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_t;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ASUB = 7'b0100000;
  localparam logic [2:0] F3_ADD      = 3'd0;
  localparam logic [2:0] F3_SLL      = 3'd1;
  localparam logic [2:0] F3_SR       = 3'd5;
  localparam logic [1:0] SIZE_WORD   = 2'd2;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_IMM, CLS_OP
  } instr_class_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_t;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} alu_b_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_t;
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JAL = 2'd2, PC_JALR = 2'd3
  } pc_sel_t;
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0, CAUSE_ILLEGAL = 2'd1, CAUSE_MISALIGNED = 2'd2, CAUSE_TIMEOUT = 2'd3
  } trap_cause_t;

  // alt selects the funct7[5] variant (SUB / SRA); callers only raise it
  // where that variant is legal.
  function automatic alu_op_t funct3_alu_op(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational instruction decoder for the multi-cycle controller.
// Ports:
//   instr   in   instruction_t  IR contents
//   cls     out  instr_class_t  instruction class
//   illegal out  1              encoding is not a supported RV32I instruction
//   alu_op  out  alu_op_t       ALU operation for EXEC
//   alu_a   out  alu_a_t        ALU operand A select
//   alu_b   out  alu_b_t        ALU operand B select
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  instruction_t instr,
  output instr_class_t cls,
  output logic         illegal,
  output alu_op_t      alu_op,
  output alu_a_t       alu_a,
  output alu_b_t       alu_b
);

  logic [2:0] f3;
  logic [6:0] f7;

  assign f3 = instr.funct3;
  assign f7 = instr.funct7;

  always_comb begin
    cls     = CLS_OP;
    illegal = 1'b0;
    alu_op  = ALU_ADD;
    alu_a   = A_RS1;
    alu_b   = B_IMM;
    case (instr.opcode)
      OPC_LUI: begin
        cls    = CLS_LUI;
        alu_a  = A_ZERO;
        alu_op = ALU_PASSB;
      end
      OPC_AUIPC: begin
        cls   = CLS_AUIPC;
        alu_a = A_PC;
      end
      OPC_JAL: begin
        cls   = CLS_JAL;
        alu_a = A_PC;
      end
      OPC_JALR: begin
        cls     = CLS_JALR;
        illegal = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        cls   = CLS_BRANCH;
        alu_b = B_RS2;
        // funct3[2:1] picks the compare family: EQ/NE, (reserved), LT/GE, LTU/GEU
        case (f3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        illegal = (f3 > 3'd2);
      end
      OPC_IMM: begin
        cls = CLS_IMM;
        // funct7 is immediate data except for the shift forms
        alu_op = funct3_alu_op(f3, (f3 == F3_SR) && f7[5]);
        if (f3 == F3_SLL) begin
          illegal = (f7 != FUNCT7_ZERO);
        end else if (f3 == F3_SR) begin
          illegal = (f7 != FUNCT7_ZERO) && (f7 != FUNCT7_ASUB);
        end
      end
      OPC_OP: begin
        cls    = CLS_OP;
        alu_b  = B_RS2;
        alu_op = funct3_alu_op(f3, f7 == FUNCT7_ASUB);
        if ((f7 != FUNCT7_ZERO) && (f7 != FUNCT7_ASUB)) begin
          illegal = 1'b1;
        end else if ((f7 == FUNCT7_ASUB) && (f3 != F3_ADD) && (f3 != F3_SR)) begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB), drives datapath selects,
// the memory handshake, PC update and register write-enable, traps on
// illegal encodings / misaligned accesses / memory timeout, counts retirements.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   instr, mem_ready, br_taken, addr_lo            inputs from datapath/memory
//   mem_req, mem_we, mem_size, mem_unsigned,
//   mem_addr_sel, ir_write                         memory interface controls
//   alu_a_sel, alu_b_sel, alu_op, reg_write,
//   wb_sel, pc_write, pc_sel                       datapath controls
//   trap, trap_cause, instret, state               status
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  instruction_t         instr,
  input  logic                 mem_ready,
  input  logic                 br_taken,
  input  logic [1:0]           addr_lo,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic [3:0]           alu_op,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 pc_write,
  output logic [1:0]           pc_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state
);

  localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W + 1)'(MEM_TIMEOUT);

  ctrl_state_t          state_reg, state_next;
  logic [WAIT_W-1:0]    wait_reg, wait_next;
  logic [WAIT_W:0]      wait_inc;
  logic                 wait_expired;
  logic                 trap_reg, trap_next;
  trap_cause_t          cause_reg, cause_next;
  logic [INSTRET_W-1:0] instret_reg, instret_next;

  instr_class_t cls;
  logic         illegal;
  alu_op_t      dec_alu_op;
  alu_a_t       dec_alu_a;
  alu_b_t       dec_alu_b;
  logic         misaligned;

  // Ungated control values; the outputs are forced low while in reset.
  logic       req_c, we_c, uns_c, addr_sel_c, ir_write_c, reg_write_c, pc_write_c;
  logic [1:0] size_c, alu_a_c, alu_b_c, wb_sel_c, pc_sel_c;
  logic [3:0] alu_op_c;

  // Register indices are consumed by the datapath, not by the controller.
  logic unused_fields;
  assign unused_fields = &{1'b0, instr.rs1, instr.rs2};

  ctrl_decode u_decode (
    .instr   (instr),
    .cls     (cls),
    .illegal (illegal),
    .alu_op  (dec_alu_op),
    .alu_a   (dec_alu_a),
    .alu_b   (dec_alu_b)
  );

  // One extra bit so the compare against MEM_TIMEOUT never wraps.
  assign wait_inc     = {1'b0, wait_reg} + (WAIT_W + 1)'(1);
  assign wait_expired = (wait_inc == WAIT_LIMIT);

  assign misaligned = ((instr.funct3[1:0] == 2'd1) && addr_lo[0]) ||
                      ((instr.funct3[1:0] == 2'd2) && (addr_lo != 2'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_FETCH;
      wait_reg    <= '0;
      trap_reg    <= 1'b0;
      cause_reg   <= CAUSE_NONE;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      trap_reg    <= trap_next;
      cause_reg   <= cause_next;
      instret_reg <= instret_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    trap_next    = trap_reg;
    cause_next   = cause_reg;
    instret_next = instret_reg;
    req_c        = 1'b0;
    we_c         = 1'b0;
    size_c       = 2'd0;
    uns_c        = 1'b0;
    addr_sel_c   = 1'b0;
    ir_write_c   = 1'b0;
    alu_a_c      = 2'd0;
    alu_b_c      = 2'd0;
    alu_op_c     = 4'd0;
    reg_write_c  = 1'b0;
    wb_sel_c     = 2'd0;
    pc_write_c   = 1'b0;
    pc_sel_c     = 2'd0;

    // ALU selects stay valid through MEM and WB so the address and
    // writeback value do not depend on an ALU output register.
    if ((state_reg == ST_EXEC) || (state_reg == ST_MEM) || (state_reg == ST_WB)) begin
      alu_a_c  = dec_alu_a;
      alu_b_c  = dec_alu_b;
      alu_op_c = dec_alu_op;
    end

    case (state_reg)
      ST_FETCH: begin
        req_c  = 1'b1;
        size_c = SIZE_WORD;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_TIMEOUT;
        end else begin
          wait_next = wait_inc[WAIT_W-1:0];
        end
      end

      ST_DECODE: begin
        if (illegal) begin
          state_next = ST_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls)
          CLS_BRANCH: begin
            pc_write_c   = 1'b1;
            pc_sel_c     = br_taken ? PC_BRANCH : PC_PLUS4;
            instret_next = instret_reg + INSTRET_W'(1);
            wait_next    = '0;
            state_next   = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            if (misaligned) begin
              state_next = ST_TRAP;
              trap_next  = 1'b1;
              cause_next = CAUSE_MISALIGNED;
            end else begin
              wait_next  = '0;
              state_next = ST_MEM;
            end
          end
          default: state_next = ST_WB;
        endcase
      end

      ST_MEM: begin
        req_c      = 1'b1;
        addr_sel_c = 1'b1;
        we_c       = (cls == CLS_STORE);
        size_c     = instr.funct3[1:0];
        uns_c      = (cls == CLS_LOAD) && instr.funct3[2];
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_write_c   = 1'b1;
            pc_sel_c     = PC_PLUS4;
            instret_next = instret_reg + INSTRET_W'(1);
            wait_next    = '0;
            state_next   = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_TIMEOUT;
        end else begin
          wait_next = wait_inc[WAIT_W-1:0];
        end
      end

      ST_WB: begin
        reg_write_c = (instr.rd != 5'd0);
        case (cls)
          CLS_LOAD:          wb_sel_c = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel_c = WB_PC4;
          default:           wb_sel_c = WB_ALU;
        endcase
        pc_write_c = 1'b1;
        case (cls)
          CLS_JAL:  pc_sel_c = PC_JAL;
          CLS_JALR: pc_sel_c = PC_JALR;
          default:  pc_sel_c = PC_PLUS4;
        endcase
        instret_next = instret_reg + INSTRET_W'(1);
        wait_next    = '0;
        state_next   = ST_FETCH;
      end

      ST_TRAP: begin
        state_next = ST_TRAP;
      end

      default: begin
        wait_next  = '0;
        state_next = ST_FETCH;
      end
    endcase
  end

  assign mem_req      = rst_n & req_c;
  assign mem_we       = rst_n & we_c;
  assign mem_size     = rst_n ? size_c : 2'd0;
  assign mem_unsigned = rst_n & uns_c;
  assign mem_addr_sel = rst_n & addr_sel_c;
  assign ir_write     = rst_n & ir_write_c;
  assign alu_a_sel    = rst_n ? alu_a_c : 2'd0;
  assign alu_b_sel    = rst_n ? alu_b_c : 2'd0;
  assign alu_op       = rst_n ? alu_op_c : 4'd0;
  assign reg_write    = rst_n & reg_write_c;
  assign wb_sel       = rst_n ? wb_sel_c : 2'd0;
  assign pc_write     = rst_n & pc_write_c;
  assign pc_sel       = rst_n ? pc_sel_c : 2'd0;
  assign trap         = rst_n & trap_reg;
  assign trap_cause   = rst_n ? cause_reg : 2'd0;
  assign instret      = instret_reg;
  assign state        = state_reg;

endmodule
